stream_in_pack: RTL and testbench
=================================

// Module: stream_in_pack
// PURPOSE
//  Parametrised input packer for the AES datapath: gathers IN_W-bit words from
//  the host stream into WORDS-word blocks, tagged with a block type (key/data/...).
//  Adds ready/valid back-pressure on both sides, a one-block holding buffer,
//  early flush of short blocks, and type-mismatch detection.
//  Sits between the host interface and the key-expansion / cipher cores.
// PARAMETERS
//  IN_W    32  input word width in bits
//  WORDS   4   words per output block; OUT_W = IN_W*WORDS; WORDS >= 2
//  TYPE_W  2   width of block type tag
// PORTS
//  clk        in   1               clock
//  rst        in   1               synchronous, active-high reset
//  in_valid   in   1               input word valid
//  in_ready   out  1               packer can accept a word this cycle
//  in_type    in   TYPE_W          type tag; sampled on first word of a block
//  in_data    in   IN_W            input word
//  in_last    in   1               word ends the block early (flush)
//  out_valid  out  1               output block valid
//  out_ready  in   1               downstream accepts block
//  out_type   out  TYPE_W          type of output block
//  out_data   out  IN_W*WORDS      packed block; first word in MSBs
//  out_count  out  clog2(WORDS+1)  number of valid words in block (1..WORDS)
//  err_type   out  1               one-cycle pulse: type changed mid-block
// BEHAVIOUR
//  - Transfer in: in_valid & in_ready; out: out_valid & out_ready.
//  - Reset: out_valid=0, out_data=0, out_type=0, out_count=0, err_type=0, word
//    counter=0, assembly empty; in_ready=0 while rst high, 1 the cycle after.
//  - Assembly reg shifts left by IN_W on each accepted word; k-th word of a
//    block lands in bits [OUT_W-1-k*IN_W -: IN_W]. Short blocks zero-padded in LSBs.
//  - Word counter 0..WORDS-1; type latched when counter==0. Final word = counter
//    reaches WORDS-1, or in_last=1 (any position); counter then wraps to 0.
//  - On final-word acceptance: if output slot free (!out_valid | out_ready) block
//    moves to output regs next edge (out_valid 1 cycle after final word); else
//    block held in assembly, asm_full=1.
//  - in_ready = !asm_full (combinational). asm_full block moves to output on the
//    edge where out_ready=1; in_ready returns 1 the following cycle.
//  - out_* hold stable while out_valid & !out_ready. out_valid drops after a
//    transfer unless a new block loads on the same edge (back-to-back allowed).
//  - Mid-block word (counter!=0) with in_type != latched type: word accepted,
//    block keeps latched type, err_type=1 for exactly one cycle.
//  - in_last on the WORDS-th word equals a normal full block (out_count=WORDS).
//  - in_valid without in_ready: ignored, no state change. Input sampled only on transfer.
//  - Reset mid-block or with output pending: partial and held blocks discarded.
//  - Throughput: 1 word/cycle sustained when out_ready is 1.
// TESTING
//  1. Defaults, out_ready=1, words 11111111,22222222,33333333,44444444 type 2 ->
//     out_data=11111111_22222222_33333333_44444444, type 2, count 4, 1 pulse.
//  2. 3 words AA.., BB.., CC.. with in_last on third -> out_data=AA_BB_CC_00000000
//     (per-word), count 3; next block starts at counter 0.
//  3. out_ready=0, stream 8 words -> first block held on out_*, in_ready=0 after
//     word 8; raise out_ready -> both blocks out in order, no loss/duplication.
//  4. Type 1 first word, type 3 on word 2 -> err_type pulse 1 cycle, out_type=1.
//  5. Assert rst after word 2 of a block -> no out_valid; next 4 words form a
//     clean block with correct ordering.
//  6. Random in_valid/out_ready, 1000 blocks vs scoreboard model; repeat IN_W=64,WORDS=2.

Source files
------------

// File: rtl/stream_in_pack.sv
// Input packer for the AES datapath: gathers IN_W-bit host words into typed
// WORDS-word blocks, with a one-block holding buffer and ready/valid on both sides.
module stream_in_pack #(
    parameter int IN_W   = 32,
    parameter int WORDS  = 4,
    parameter int TYPE_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [TYPE_W-1:0]            in_type,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TYPE_W-1:0]            out_type,
    output logic [IN_W*WORDS-1:0]        out_data,
    output logic [$clog2(WORDS+1)-1:0]   out_count,
    output logic                         err_type
);

    localparam int OUT_W = IN_W * WORDS;
    localparam int CNT_W = $clog2(WORDS);
    localparam int OC_W  = $clog2(WORDS + 1);

    typedef enum logic {
        ST_FILL,
        ST_HELD
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    word_cnt;
    logic [OUT_W-1:0]    asm_data;
    logic [TYPE_W-1:0]   asm_type;
    logic [OC_W-1:0]     asm_count;

    logic                in_fire;
    logic                slot_free;
    logic                final_word;
    logic                type_err;
    logic [OUT_W-1:0]    asm_next;
    logic [TYPE_W-1:0]   type_next;
    logic [OC_W-1:0]     count_next;

    // While a finished block waits in the assembly register, input stalls.
    assign in_ready   = (state == ST_FILL) && !rst;
    assign in_fire    = in_valid && in_ready;
    assign slot_free  = !out_valid || out_ready;
    assign final_word = (word_cnt == CNT_W'(WORDS - 1)) || in_last;
    assign type_err   = in_fire && (word_cnt != '0) && (in_type != asm_type);

    // A fresh block starts from zero so short blocks come out padded in the LSBs.
    always_comb begin
        asm_next   = (word_cnt == '0) ? '0 : asm_data;
        type_next  = (word_cnt == '0) ? in_type : asm_type;
        count_next = OC_W'(word_cnt) + OC_W'(1);
        for (int k = 0; k < WORDS; k++) begin
            if (word_cnt == CNT_W'(k)) begin
                asm_next[OUT_W-1-k*IN_W -: IN_W] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL;
            word_cnt  <= '0;
            asm_data  <= '0;
            asm_type  <= '0;
            asm_count <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_type  <= '0;
            out_count <= '0;
            err_type  <= 1'b0;
        end else begin
            err_type <= type_err;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_HELD: begin
                    if (out_ready) begin
                        out_valid <= 1'b1;
                        out_data  <= asm_data;
                        out_type  <= asm_type;
                        out_count <= asm_count;
                        state     <= ST_FILL;
                    end
                end
                default: begin
                    if (in_fire) begin
                        if (final_word) begin
                            word_cnt <= '0;
                            if (slot_free) begin
                                out_valid <= 1'b1;
                                out_data  <= asm_next;
                                out_type  <= type_next;
                                out_count <= count_next;
                            end else begin
                                asm_data  <= asm_next;
                                asm_type  <= type_next;
                                asm_count <= count_next;
                                state     <= ST_HELD;
                            end
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                            asm_data <= asm_next;
                            asm_type <= type_next;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_in_pack.sv
// Scoreboard bench for stream_in_pack: two instances (32x4 and 64x2), one active
// at a time, checked against a word-list reference model of block assembly.
module tb_stream_in_pack;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   typ;
        logic [2:0]   cnt;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sel = 1'b0;
    logic         d_valid = 1'b0;
    logic         d_last = 1'b0;
    logic         d_ready = 1'b1;
    logic [63:0]  d_data = '0;
    logic [1:0]   d_type = '0;

    logic         in_valid_a, in_ready_a, out_valid_a, err_type_a;
    logic [1:0]   out_type_a;
    logic [127:0] out_data_a;
    logic [2:0]   out_count_a;
    logic         in_valid_b, in_ready_b, out_valid_b, err_type_b;
    logic [1:0]   out_type_b;
    logic [127:0] out_data_b;
    logic [1:0]   out_count_b;

    logic         m_in_ready, m_valid, m_err;
    logic [1:0]   m_type;
    logic [127:0] m_data;
    logic [2:0]   m_count;

    int           checks = 0;
    int           fails = 0;
    int           obs_err = 0;
    int           exp_err = 0;
    blk_t         exp_q[$];
    int           m_len = 0;
    logic [127:0] m_acc = '0;
    logic [1:0]   m_typ = '0;
    logic         prev_hold = 1'b0;
    logic [127:0] prev_data = '0;
    logic [1:0]   prev_type = '0;
    logic [2:0]   prev_count = '0;
    logic [127:0] last_data = '0;
    logic [1:0]   last_type = '0;
    logic [2:0]   last_count = '0;
    logic         rnd_on = 1'b0;

    always #5 clk = ~clk;

    assign in_valid_a = d_valid && !sel;
    assign in_valid_b = d_valid && sel;
    assign m_in_ready = sel ? in_ready_b : in_ready_a;
    assign m_valid    = sel ? out_valid_b : out_valid_a;
    assign m_err      = sel ? err_type_b : err_type_a;
    assign m_type     = sel ? out_type_b : out_type_a;
    assign m_data     = sel ? out_data_b : out_data_a;
    assign m_count    = sel ? {1'b0, out_count_b} : out_count_a;

    stream_in_pack #(.IN_W(32), .WORDS(4), .TYPE_W(2)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_type(d_type),
        .in_data(d_data[31:0]), .in_last(d_last),
        .out_valid(out_valid_a), .out_ready(d_ready), .out_type(out_type_a),
        .out_data(out_data_a), .out_count(out_count_a), .err_type(err_type_a)
    );

    stream_in_pack #(.IN_W(64), .WORDS(2), .TYPE_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_type(d_type),
        .in_data(d_data), .in_last(d_last),
        .out_valid(out_valid_b), .out_ready(d_ready), .out_type(out_type_b),
        .out_data(out_data_b), .out_count(out_count_b), .err_type(err_type_b)
    );

    function automatic int cfgInW();
        return sel ? 64 : 32;
    endfunction

    function automatic int cfgWords();
        return sel ? 2 : 4;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a block is the list of accepted words, first word in the MSBs.
    task automatic modelAccept(input logic [63:0] data, input logic [1:0] typ, input logic last);
        logic [127:0] mask;
        mask = (128'd1 << cfgInW()) - 128'd1;
        if (m_len == 0) begin
            m_typ = typ;
            m_acc = '0;
        end else if (typ != m_typ) begin
            exp_err++;
        end
        m_acc = m_acc | (({64'd0, data} & mask) << (128 - (m_len + 1) * cfgInW()));
        m_len++;
        if (m_len == cfgWords() || last) begin
            exp_q.push_back('{data: m_acc, typ: m_typ, cnt: 3'(m_len)});
            m_len = 0;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic [1:0] typ, input logic last);
        logic got;
        int   waited;
        waited  = 0;
        d_valid = 1'b1;
        d_data  = data;
        d_type  = typ;
        d_last  = last;
        got     = 1'b0;
        while (!got && waited < 500) begin
            @(negedge clk);
            got = m_in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (got) begin
            modelAccept(data, typ, last);
        end else begin
            checkOutput("accept_timeout", 128'(got), 128'd1);
        end
        d_valid = 1'b0;
        d_last  = 1'b0;
    endtask

    task automatic monitorStep();
        blk_t e;
        if (rst) begin
            prev_hold = 1'b0;
            return;
        end
        if (prev_hold) begin
            checkOutput("hold_valid", 128'(m_valid), 128'd1);
            checkOutput("hold_data", m_data, prev_data);
            checkOutput("hold_type", 128'(m_type), 128'(prev_type));
            checkOutput("hold_count", 128'(m_count), 128'(prev_count));
        end
        if (m_err) obs_err++;
        if (m_valid && d_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_block: got %h expected no block", m_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("blk_data", m_data, e.data);
                checkOutput("blk_type", 128'(m_type), 128'(e.typ));
                checkOutput("blk_count", 128'(m_count), 128'(e.cnt));
            end
            last_data  = m_data;
            last_type  = m_type;
            last_count = m_count;
        end
        prev_hold  = m_valid && !d_ready;
        prev_data  = m_data;
        prev_type  = m_type;
        prev_count = m_count;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic doReset();
        rst     = 1'b1;
        d_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 128'(m_in_ready), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_len = 0;
        exp_q.delete();
        obs_err = 0;
        exp_err = 0;
        @(negedge clk);
        checkOutput("rst_out_valid", 128'(m_valid), 128'd0);
        checkOutput("rst_out_data", m_data, 128'd0);
        checkOutput("rst_out_type", 128'(m_type), 128'd0);
        checkOutput("rst_out_count", 128'(m_count), 128'd0);
        checkOutput("rst_err_type", 128'(m_err), 128'd0);
        checkOutput("rst_in_ready_after", 128'(m_in_ready), 128'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic runRandom(input int nblocks);
        int    words, len;
        logic [1:0] base, t;
        logic  last;
        words  = cfgWords();
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    if (rnd_on) d_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int b = 0; b < nblocks; b++) begin
            len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, words)) : words;
            base = 2'($urandom_range(0, 3));
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                t    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : base;
                last = (w == len - 1) && ((len < words) || ($urandom_range(0, 1) == 1));
                applyStimulus({$urandom, $urandom}, t, last);
            end
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #1;
        d_ready = 1'b1;
        waitDrain();
        checkOutput("rand_err_count", 128'(obs_err), 128'(exp_err));
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none

        @(posedge clk);
        #1;
        doReset();

        // Full block, then a literal check independent of the model.
        applyStimulus(64'h11111111, 2'd2, 1'b0);
        applyStimulus(64'h22222222, 2'd2, 1'b0);
        applyStimulus(64'h33333333, 2'd2, 1'b0);
        applyStimulus(64'h44444444, 2'd2, 1'b0);
        waitDrain();
        checkOutput("t1_data", last_data, 128'h11111111_22222222_33333333_44444444);
        checkOutput("t1_type", 128'(last_type), 128'd2);
        checkOutput("t1_count", 128'(last_count), 128'd4);

        // Short block flushed by in_last, then a full block from counter 0.
        applyStimulus(64'hAAAAAAAA, 2'd1, 1'b0);
        applyStimulus(64'hBBBBBBBB, 2'd1, 1'b0);
        applyStimulus(64'hCCCCCCCC, 2'd1, 1'b1);
        waitDrain();
        checkOutput("t2_data", last_data, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_00000000);
        checkOutput("t2_count", 128'(last_count), 128'd3);
        for (int i = 0; i < 4; i++) applyStimulus(64'(32'h50 + i), 2'd0, 1'b0);
        waitDrain();
        checkOutput("t2_next", last_data, 128'h00000050_00000051_00000052_00000053);

        // Back-pressure: second block held in the assembly register.
        d_ready = 1'b0;
        for (int i = 1; i <= 8; i++) applyStimulus(64'(i), 2'd3, 1'b0);
        @(negedge clk);
        checkOutput("t3_in_ready_low", 128'(m_in_ready), 128'd0);
        checkOutput("t3_held_out", m_data, 128'h00000001_00000002_00000003_00000004);
        @(posedge clk);
        #1;
        d_valid = 1'b1;
        d_data  = 64'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        d_valid = 1'b0;
        d_ready = 1'b1;
        waitDrain();
        checkOutput("t3_last", last_data, 128'h00000005_00000006_00000007_00000008);
        checkOutput("t3_in_ready_back", 128'(m_in_ready), 128'd1);

        // Type change mid-block.
        applyStimulus(64'h1, 2'd1, 1'b0);
        applyStimulus(64'h2, 2'd3, 1'b0);
        applyStimulus(64'h3, 2'd1, 1'b0);
        applyStimulus(64'h4, 2'd1, 1'b0);
        waitDrain();
        checkOutput("t4_type", 128'(last_type), 128'd1);
        checkOutput("t4_err_pulses", 128'(obs_err), 128'd1);

        // Reset mid-block discards the partial block.
        applyStimulus(64'h77, 2'd2, 1'b0);
        applyStimulus(64'h78, 2'd2, 1'b0);
        doReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_no_valid", 128'(m_valid), 128'd0);
        for (int i = 0; i < 4; i++) applyStimulus(64'(32'h90 + i), 2'd0, 1'b0);
        waitDrain();
        checkOutput("t5_clean", last_data, 128'h00000090_00000091_00000092_00000093);

        runRandom(1000);

        sel = 1'b1;
        doReset();
        applyStimulus(64'h0123456789ABCDEF, 2'd1, 1'b0);
        applyStimulus(64'hFEDCBA9876543210, 2'd1, 1'b0);
        waitDrain();
        checkOutput("w64_data", last_data, 128'h0123456789ABCDEF_FEDCBA9876543210);
        runRandom(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
